bowling_throw_entry: RTL and testbench
======================================

# bowling_throw_entry

Upstream stage of `BowlingGameSystem` that converts a raw push-button plus a 4-bit pin switch bank into validated, single-cycle throw updates. It debounces the button, tracks frame and ball position, rejects pin counts that exceed the pins still standing, and drives the `upd`, `N` and `LF` inputs of the scoring block. Throws are ignored once the game is complete.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 4: the synchronized button must hold a new level for this many consecutive cycles before the level is accepted. Use a large value on hardware.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `btn`  in  1  raw, asynchronous throw-enter button; may bounce.
- `sw_pins`  in  4  pins knocked down this ball.
- `game_done`  in  1  `done` from the scoring block.
- `upd`  out  1  one-cycle pulse for an accepted throw.
- `N`  out  4  pin count. Valid only while `upd`=1; otherwise 0.
- `LF`  out  1  high while the current frame is the 10th (`frame_idx`==9).
- `err`  out  1  one-cycle pulse for a rejected throw.
- `frame_idx`  out  4  current frame, 0..9.
- `ball_idx`  out  2  ball within the frame, 0..2.
- `pins_left`  out  4  pins currently standing, 0..10.
- `finished`  out  1  high once no further throws are accepted.

## Operation

Button path:
- `btn` passes through a 2-flop synchronizer, then a debounce counter, then rising-edge detection, producing a one-cycle `press`.
- After reset the block is disarmed. It arms only after the debounced level has been observed low. A button held through reset therefore produces no press.

Validation of each `press`:
- Invalid when `sw_pins` > `pins_left`, which also covers any value above 10. An invalid press pulses `err`, leaves `upd`=0 and changes no state.
- A press while `finished`=1 or `game_done`=1 is dropped silently: no `upd`, no `err`.

FSM states: BALL1, BALL2, BONUS1, BONUS2, FINISHED.
- **BALL1:**
  - Strike before frame 10: `frame_idx`+1, `pins_left`=10, stay in BALL1.
  - Strike in frame 10: go to BONUS1, `pins_left`=10.
  - Otherwise: `pins_left`=10−N, go to BALL2.
- **BALL2:**
  - Frames 0..8: `frame_idx`+1, `pins_left`=10, go to BALL1.
  - Frame 9, spare: go to BONUS2, `pins_left`=10.
  - Frame 9, open: go to FINISHED.
- **BONUS1:** `pins_left` = 10 if N==10, else 10−N; go to BONUS2.
- **BONUS2:** go to FINISHED.
- **FINISHED:** terminal until reset. `finished`=1.

Ball index:
- `ball_idx` is 0 in BALL1, 1 in BALL2 and BONUS1, and 2 in BONUS2.
- It is frame-relative and only meaningful in frame 10 for index 2.

Arithmetic:
- All pin values are 4-bit unsigned.
- 10−N is computed only after validation, so it never underflows.
- `frame_idx` never exceeds 9.

Reset values:
- `upd`=0, `N`=0, `err`=0, `LF`=0, `frame_idx`=0, `ball_idx`=0, `pins_left`=10, `finished`=0.
- State BALL1, debounced level 0, disarmed.

## Timing

Press latency:
- Let e0 be the first edge that samples `btn`=1 with the bounce settled.
- `upd` or `err` is high for exactly the cycle after edge e0+DEBOUNCE_CYCLES+2.
- `N` is registered alongside `upd` from the synchronized `sw_pins` sample.

Outputs:
- `frame_idx`, `ball_idx`, `pins_left`, `LF` and `finished` update on the same edge that raises `upd`. They are stable before the downstream block samples.
- `LF` reflects the frame being entered, so it is already 1 on the `upd` of the first ball of frame 10.

Spacing:
- Each press yields exactly one pulse.
- The next press needs the debounced level to go low and then high again, so the minimum spacing is 2·DEBOUNCE_CYCLES+2 cycles.

Boundary cases:
- Bounce shorter than DEBOUNCE_CYCLES produces no pulse.
- `reset` asserted mid-debounce or mid-frame returns everything to reset values on the next edge. Any pending press is lost.
- `game_done` rising in the same cycle as `press`: the press is dropped.

## Structure

Package `bowling_pkg`:
- `PINS_MAX`=10, `FRAME_LAST`=9.
- State enum `throw_state_t`.
- Shared with the scoring block.

Sub-module `btn_debounce`:
- Contains the synchronizer, counter, arm flag and edge detector.
- Ports: `clk`, `reset`, `btn`, `press`.
- Parameter: `DEBOUNCE_CYCLES`.

The top-level block holds the validation logic and the FSM.

## Test plan

1. Clean press with `sw_pins`=10 in frame 0 → one `upd` with N=10, exactly DEBOUNCE_CYCLES+3 cycles after e0; then `frame_idx`=1, `pins_left`=10.
2. Enter 4, then 7 in the same frame → first press gives `upd`/N=4 and `pins_left`=6; second press gives `err` pulse only, with state unchanged. Entering 6 next gives `upd`/N=6 and `frame_idx`+1.
3. Bouncing `btn` (1-cycle glitches, then a stable hold) → exactly one `upd`. Glitches shorter than DEBOUNCE_CYCLES alone → nothing.
4. Full game of 9 strikes, then 10, 10, 10 → `LF`=1 from the first frame-10 `upd`; `ball_idx` goes 0,1,2; `finished`=1 after the 12th `upd`; a further press gives no `upd` and no `err`.
5. Frame 10 entered as 3, 4 → `finished`=1 after the second ball and no bonus is accepted. Frame 10 entered as 3, 7 → exactly one bonus ball with `pins_left`=10.
6. Hold `btn` high across `reset` deassertion → no `upd` until release and re-press. Reset mid-frame (`pins_left`=6) → `pins_left`=10, `frame_idx`=0.

Source files
------------

// File: rtl/bowling_pkg.sv
// rtl/bowling_pkg.sv - shared constants and throw-entry state encoding
package bowling_pkg;

  localparam logic [3:0] PINS_MAX   = 4'd10;
  localparam logic [3:0] FRAME_LAST = 4'd9;

  typedef enum logic [2:0] {
    BALL1    = 3'd0,
    BALL2    = 3'd1,
    BONUS1   = 3'd2,
    BONUS2   = 3'd3,
    FINISHED = 3'd4
  } throw_state_t;

endpackage

// File: rtl/bowling_throw_entry_debounce.sv
// rtl/bowling_throw_entry_debounce.sv - button synchronizer, debouncer, arm flag and press edge detector
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          level_prev_q, level_prev_d;
  logic          armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] arm_cnt_q, arm_cnt_d;

  always_comb begin
    sync1_d      = btn;
    sync2_d      = sync1_q;
    level_prev_d = level_q;
    level_d      = level_q;
    cnt_d        = '0;
    armed_d      = armed_q;
    arm_cnt_d    = '0;

    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // Arming needs a confirmed low on the raw synchronized input, so a
    // button held through reset cannot arm off the reset value of level_q.
    if (!armed_q && !level_q && !sync2_q) begin
      if (arm_cnt_q == CNT_LAST) begin
        armed_d = 1'b1;
      end else begin
        arm_cnt_d = arm_cnt_q + CW'(1);
      end
    end
  end

  assign press = armed_q && level_q && !level_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      armed_q      <= 1'b0;
      cnt_q        <= '0;
      arm_cnt_q    <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      armed_q      <= armed_d;
      cnt_q        <= cnt_d;
      arm_cnt_q    <= arm_cnt_d;
    end
  end

endmodule

// File: rtl/bowling_throw_entry.sv
// rtl/bowling_throw_entry.sv - validates debounced throws and tracks frame/ball position
module bowling_throw_entry
  import bowling_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  input  logic [3:0] sw_pins,
  input  logic       game_done,
  output logic       upd,
  output logic [3:0] N,
  output logic       LF,
  output logic       err,
  output logic [3:0] frame_idx,
  output logic [1:0] ball_idx,
  output logic [3:0] pins_left,
  output logic       finished
);

  logic         press;
  logic [3:0]   sw_sync1_q, sw_sync1_d;
  logic [3:0]   sw_sync2_q, sw_sync2_d;
  throw_state_t state_q, state_d;
  logic [3:0]   frame_q, frame_d;
  logic [3:0]   pins_left_q, pins_left_d;
  logic         upd_q, upd_d;
  logic [3:0]   n_q, n_d;
  logic         err_q, err_d;
  logic         live;
  logic [3:0]   remain;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .reset(reset),
    .btn  (btn),
    .press(press)
  );

  // Pin switches share the button's synchronizer depth so N lines up with press.
  assign live   = press && (state_q != FINISHED) && !game_done;
  assign remain = pins_left_q - sw_sync2_q;

  always_comb begin
    sw_sync1_d  = sw_pins;
    sw_sync2_d  = sw_sync1_q;
    state_d     = state_q;
    frame_d     = frame_q;
    pins_left_d = pins_left_q;
    upd_d       = 1'b0;
    n_d         = 4'd0;
    err_d       = 1'b0;

    if (live) begin
      if (sw_sync2_q > pins_left_q) begin
        err_d = 1'b1;
      end else begin
        upd_d = 1'b1;
        n_d   = sw_sync2_q;
        unique case (state_q)
          BALL1: begin
            if (sw_sync2_q == PINS_MAX) begin
              pins_left_d = PINS_MAX;
              if (frame_q == FRAME_LAST) begin
                state_d = BONUS1;
              end else begin
                frame_d = frame_q + 4'd1;
              end
            end else begin
              pins_left_d = remain;
              state_d     = BALL2;
            end
          end
          BALL2: begin
            if (frame_q != FRAME_LAST) begin
              frame_d     = frame_q + 4'd1;
              pins_left_d = PINS_MAX;
              state_d     = BALL1;
            end else if (sw_sync2_q == pins_left_q) begin
              pins_left_d = PINS_MAX;
              state_d     = BONUS2;
            end else begin
              pins_left_d = remain;
              state_d     = FINISHED;
            end
          end
          BONUS1: begin
            pins_left_d = (sw_sync2_q == PINS_MAX) ? PINS_MAX : remain;
            state_d     = BONUS2;
          end
          BONUS2: begin
            pins_left_d = remain;
            state_d     = FINISHED;
          end
          default: begin
            state_d = FINISHED;
          end
        endcase
      end
    end
  end

  always_comb begin
    ball_idx = 2'd0;
    unique case (state_q)
      BALL1:    ball_idx = 2'd0;
      BALL2:    ball_idx = 2'd1;
      BONUS1:   ball_idx = 2'd1;
      BONUS2:   ball_idx = 2'd2;
      default:  ball_idx = 2'd2;
    endcase
  end

  assign upd       = upd_q;
  assign N         = n_q;
  assign err       = err_q;
  assign frame_idx = frame_q;
  assign pins_left = pins_left_q;
  assign LF        = (frame_q == FRAME_LAST);
  assign finished  = (state_q == FINISHED);

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_sync1_q  <= 4'd0;
      sw_sync2_q  <= 4'd0;
      state_q     <= BALL1;
      frame_q     <= 4'd0;
      pins_left_q <= PINS_MAX;
      upd_q       <= 1'b0;
      n_q         <= 4'd0;
      err_q       <= 1'b0;
    end else begin
      sw_sync1_q  <= sw_sync1_d;
      sw_sync2_q  <= sw_sync2_d;
      state_q     <= state_d;
      frame_q     <= frame_d;
      pins_left_q <= pins_left_d;
      upd_q       <= upd_d;
      n_q         <= n_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_bowling_throw_entry.sv
// tb/tb_bowling_throw_entry.sv - table-driven bench for bowling_throw_entry
module tb_bowling_throw_entry;

  localparam int D = 4;
  localparam int LAT = D + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn = 1'b0;
  logic [3:0] sw_pins = 4'd0;
  logic       game_done = 1'b0;
  logic       upd, LF, err, finished;
  logic [3:0] N, frame_idx, pins_left;
  logic [1:0] ball_idx;

  int checks = 0;
  int errors = 0;

  bowling_throw_entry #(.DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn      (btn),
    .sw_pins  (sw_pins),
    .game_done(game_done),
    .upd      (upd),
    .N        (N),
    .LF       (LF),
    .err      (err),
    .frame_idx(frame_idx),
    .ball_idx (ball_idx),
    .pins_left(pins_left),
    .finished (finished)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    logic [3:0] pins;
    bit         e_upd;
    bit         e_err;
    int         e_frame;
    int         e_ball;
    int         e_pl;
    bit         e_lf;
    bit         e_fin;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit rst, input logic [3:0] pins, input bit u, input bit e,
                              input int f, input int b, input int pl, input bit lf, input bit fin);
    vec_t v;
    v = '{rst, pins, u, e, f, b, pl, lf, fin};
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    btn = 1'b0;
    game_done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic do_press(input logic [3:0] p, output bit got_upd, output bit got_err,
                          output int lat, output int got_n, output int pulse_len);
    @(negedge clk);
    sw_pins = p;
    btn = 1'b1;
    lat = -1;
    got_n = 0;
    got_upd = 1'b0;
    got_err = 1'b0;
    pulse_len = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (upd || err) begin
        lat = k;
        got_n = int'(N);
        got_upd = upd;
        got_err = err;
        break;
      end
    end
    if (lat >= 0) begin
      pulse_len = 1;
      @(posedge clk);
      #1;
      if (upd || err) pulse_len = 2;
    end
    @(negedge clk);
    btn = 1'b0;
    repeat (2 * D + 8) @(negedge clk);
  endtask

  initial begin
    bit gu, ge;
    int lat, gn, plen, cnt_u, cnt_e;

    add(1, 10, 1, 0, 1, 0, 10, 0, 0);
    add(1, 4, 1, 0, 0, 1, 6, 0, 0);
    add(0, 7, 0, 1, 0, 1, 6, 0, 0);
    add(0, 6, 1, 0, 1, 0, 10, 0, 0);
    for (int g = 0; g < 3; g++) begin
      for (int k = 1; k <= 9; k++) add(k == 1, 10, 1, 0, k, 0, 10, k == 9, 0);
      if (g == 0) begin
        add(0, 10, 1, 0, 9, 1, 10, 1, 0);
        add(0, 10, 1, 0, 9, 2, 10, 1, 0);
        add(0, 10, 1, 0, 9, 0, 0, 1, 1);
        add(0, 5, 0, 0, 9, 0, 0, 1, 1);
      end else if (g == 1) begin
        add(0, 3, 1, 0, 9, 1, 7, 1, 0);
        add(0, 4, 1, 0, 9, 0, 0, 1, 1);
        add(0, 5, 0, 0, 9, 0, 0, 1, 1);
      end else begin
        add(0, 3, 1, 0, 9, 1, 7, 1, 0);
        add(0, 7, 1, 0, 9, 2, 10, 1, 0);
        add(0, 11, 0, 1, 9, 2, 10, 1, 0);
        add(0, 5, 1, 0, 9, 0, 0, 1, 1);
        add(0, 5, 0, 0, 9, 0, 0, 1, 1);
      end
    end

    repeat (3) @(negedge clk);
    check("rst_upd", upd, 0);
    check("rst_N", N, 0);
    check("rst_err", err, 0);
    check("rst_LF", LF, 0);
    check("rst_frame", frame_idx, 0);
    check("rst_ball", ball_idx, 0);
    check("rst_pins_left", pins_left, 10);
    check("rst_finished", finished, 0);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      do_press(tbl[i].pins, gu, ge, lat, gn, plen);
      check($sformatf("v%0d_upd", i), gu, tbl[i].e_upd);
      check($sformatf("v%0d_err", i), ge, tbl[i].e_err);
      if (tbl[i].e_upd) check($sformatf("v%0d_N", i), gn, int'(tbl[i].pins));
      if (tbl[i].e_upd || tbl[i].e_err) begin
        check($sformatf("v%0d_latency", i), lat, LAT);
        check($sformatf("v%0d_pulse_len", i), plen, 1);
      end
      check($sformatf("v%0d_frame", i), frame_idx, tbl[i].e_frame);
      check($sformatf("v%0d_LF", i), LF, tbl[i].e_lf);
      check($sformatf("v%0d_finished", i), finished, tbl[i].e_fin);
      if (!tbl[i].e_fin) begin
        check($sformatf("v%0d_ball", i), ball_idx, tbl[i].e_ball);
        check($sformatf("v%0d_pins_left", i), pins_left, tbl[i].e_pl);
      end
    end

    // Bouncing press: one-cycle glitches, then a stable hold.
    do_reset();
    sw_pins = 4'd10;
    cnt_u = 0;
    cnt_e = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      btn = (i < 6) ? ((i % 2) == 0) : 1'b1;
      @(posedge clk);
      #1;
      if (upd) cnt_u++;
      if (err) cnt_e++;
    end
    @(negedge clk);
    btn = 1'b0;
    repeat (2 * D + 8) @(negedge clk);
    check("bounce_upd_count", cnt_u, 1);
    check("bounce_err_count", cnt_e, 0);
    check("bounce_frame", frame_idx, 1);

    // Glitches shorter than the debounce window only.
    cnt_u = 0;
    cnt_e = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      btn = (i < 24) ? ((i % 6) < (D - 1)) : 1'b0;
      @(posedge clk);
      #1;
      if (upd) cnt_u++;
      if (err) cnt_e++;
    end
    check("glitch_upd_count", cnt_u, 0);
    check("glitch_err_count", cnt_e, 0);
    check("glitch_frame", frame_idx, 1);

    // Button held across reset deassertion.
    @(negedge clk);
    reset = 1'b1;
    btn = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    cnt_u = 0;
    cnt_e = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (upd) cnt_u++;
      if (err) cnt_e++;
    end
    check("held_reset_upd", cnt_u, 0);
    check("held_reset_err", cnt_e, 0);
    @(negedge clk);
    btn = 1'b0;
    repeat (30) @(negedge clk);
    do_press(4'd10, gu, ge, lat, gn, plen);
    check("repress_upd", gu, 1);
    check("repress_latency", lat, LAT);
    check("repress_frame", frame_idx, 1);

    // Reset in the middle of a frame.
    do_reset();
    do_press(4'd4, gu, ge, lat, gn, plen);
    check("midframe_pins_left", pins_left, 6);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_pins_left", pins_left, 10);
    check("midreset_frame", frame_idx, 0);
    check("midreset_ball", ball_idx, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // game_done high during the press drops it silently.
    game_done = 1'b1;
    do_press(4'd5, gu, ge, lat, gn, plen);
    check("gd_upd", gu, 0);
    check("gd_err", ge, 0);
    check("gd_pins_left", pins_left, 10);
    check("gd_ball", ball_idx, 0);
    game_done = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
